sram1_lsu: RTL and testbench
============================

# sram1_lsu

Load/store initiator that drives the `sram1` word memory on behalf of the core. Accepts one byte/halfword/word request at a time over a valid/ready handshake, range- and alignment-checks it, sequences the `sram1` `read_write`/`address`/`data_in`/`data_out` pins, and returns a one-cycle response. Sub-word stores are done as read-modify-write. Sits between the core's memory stage and `sram1`.

## Interface

- `BASE_ADDR`, 32'h20000000, first byte address of `sram1`
- `SIZE_BYTES`, 32'h00018000, `sram1` size in bytes (last valid byte 0x20017FFF)

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept this cycle
- `req_write`  in  1  1 store, 0 load
- `req_size`  in  2  0 byte, 1 halfword, 2 word, 3 reserved
- `req_signed`  in  1  sign-extend sub-word loads
- `req_address`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  32  load result, extended; 0 for stores and faults
- `rsp_fault`  out  2  0 ok, 1 out of range, 2 misaligned, 3 bad size
- `mem_read_write`  out  1  to `sram1.read_write`; 1 writes at the next edge
- `mem_address`  out  32  to `sram1.address`, always word-aligned
- `mem_data_out`  out  32  to `sram1.data_in`
- `mem_data_in`  in  32  from `sram1.data_out`; valid the cycle after the read address edge

## Operation

- States: IDLE, READ, CAPTURE, WRITE, RESP.
- `req_ready` = 1 only in IDLE with `reset` low. Accept = `req_valid & req_ready` at an edge; request fields latched.
- Checks at accept, in priority order:
  - size 3 -> fault 3
  - range fault 1 unless `addr >= BASE_ADDR` and `addr + bytes - 1 <= BASE_ADDR + SIZE_BYTES - 1`; computed in 33 bits, no wrap
  - misaligned fault 2 on halfword with `addr[0]`, or word with `addr[1:0] != 0`
- Faulted request goes IDLE -> RESP with no memory access.
- Word store: IDLE -> WRITE -> RESP.
- Load: IDLE -> READ -> CAPTURE -> RESP.
- Sub-word store: IDLE -> READ -> CAPTURE -> WRITE -> RESP.
- `mem_address = {addr[31:2], 2'b00}` in READ and WRITE.
- `mem_read_write = 1` only in WRITE.
- In all other states `mem_read_write`, `mem_address` and `mem_data_out` are 0.
- Lanes are little-endian: byte k occupies bits [8k+7:8k]. Halfword at `addr[1]` occupies bits [16h+15:16h].
- CAPTURE, load: extract the lane from `mem_data_in`; zero- or sign-extend per `req_signed`; word loads ignore `req_signed`. Register into `rsp_rdata`.
- CAPTURE, sub-word store: merge `req_wdata` low bits into the lane of `mem_data_in`. The merged word is registered and driven on `mem_data_out` in WRITE.
- RESP: `rsp_valid` = 1 for exactly one cycle; no backpressure. RESP -> IDLE unconditionally.

## Timing

- Accept edge = E0.
- Fault: `rsp_valid` in the cycle after E0.
- Word store: WRITE cycle after E0, memory written at E1, `rsp_valid` after E1 (latency 2).
- Load: READ after E0, CAPTURE after E1, `rsp_valid` after E2 (latency 3).
- Sub-word store: latency 4.
- Next accept is no earlier than the cycle after RESP.
- Reset values: `req_ready` 0 while `reset` is high, 1 after release. All other outputs 0. State IDLE.
- Reset mid-operation drives `mem_read_write` to 0 immediately and asynchronously. No write occurs on the following edge, and no `rsp_valid` is produced for the abandoned request.

## Structure

- `sram1_pkg` holds:
  - `SRAM1_BASE` and `SRAM1_SIZE`
  - size encodings
  - fault codes
  - state typedef
- Sub-module `sram1_lane_mux` is combinational lane extract/extend plus lane merge, shared by the load and read-modify-write paths.
- The FSM and the request/response registers live in `sram1_lsu`.

## Test plan

All scenarios run against a real `sram1` instance.

- Word store 0x01234567 @0x20000000, then word load @0x20000000 -> store `rsp_valid` at latency 2 with fault 0; load `rsp_rdata` 0x01234567 at latency 3.
- Byte store 0xAA @0x20000002, then:
  - word load -> 0x01AA4567
  - signed byte load @0x20000002 -> 0xFFFFFFAA
  - unsigned -> 0x000000AA
- Halfword store 0x8001 @0x20000000, then:
  - word load -> 0x01AA8001
  - signed halfword load @0x20000000 -> 0xFFFF8001
  - signed halfword @0x20000002 -> 0x000001AA
- Range boundaries:
  - word store @0x20018000 -> fault 1, `mem_read_write` never 1
  - word @0x20017FFC -> ok
  - word @0x20017FFD -> fault 1, not 2
  - byte @0x20017FFF -> ok
  - word @0x1FFFFFFC -> fault 1
- Halfword load @0x20000001 -> fault 2 at latency 1. `req_size` 3 -> fault 3. `rsp_rdata` 0 in both cases.
- Assert `reset` during the WRITE cycle of a byte store -> `mem_read_write` falls the same cycle, the word is unchanged on reload, no `rsp_valid`, and `req_ready` returns to 1 after release.

Source files
------------

// File: rtl/sram1_pkg.sv
// rtl/sram1_pkg.sv - sram1 address map, request encodings, fault codes and LSU states
package sram1_pkg;

  localparam logic [31:0] SRAM1_BASE = 32'h2000_0000;
  localparam logic [31:0] SRAM1_SIZE = 32'h0001_8000;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    FAULT_NONE  = 2'd0,
    FAULT_RANGE = 2'd1,
    FAULT_ALIGN = 2'd2,
    FAULT_SIZE  = 2'd3
  } fault_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Range math is 33 bits wide so an access near 0xFFFFFFFF cannot wrap into the window.
  function automatic fault_e check_req(input logic [1:0] size, input logic [31:0] addr,
                                       input logic [31:0] base, input logic [31:0] span);
    logic [32:0] last_byte;
    logic [32:0] limit;
    last_byte = {1'b0, addr} + (33'd1 << size) - 33'd1;
    limit     = {1'b0, base} + {1'b0, span} - 33'd1;
    if (size == SIZE_RSVD) return FAULT_SIZE;
    if (addr < base || last_byte > limit) return FAULT_RANGE;
    if ((size == SIZE_HALF && addr[0]) || (size == SIZE_WORD && addr[1:0] != 2'b00))
      return FAULT_ALIGN;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/sram1_lane_mux.sv
// rtl/sram1_lane_mux.sv - little-endian lane extract/extend and store-lane merge
module sram1_lane_mux
  import sram1_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word_i[{lane_i, 3'b000} +: 8];
  assign half_lane = word_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    load_o  = word_i;
    merge_o = wdata_i;
    case (size_i)
      SIZE_BYTE: begin
        load_o  = {{24{signed_i & byte_lane[7]}}, byte_lane};
        merge_o = word_i;
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_HALF: begin
        load_o  = {{16{signed_i & half_lane[15]}}, half_lane};
        merge_o = word_i;
        merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram1_lsu.sv
// rtl/sram1_lsu.sv - single-outstanding load/store initiator for the sram1 word memory
module sram1_lsu
  import sram1_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = SRAM1_BASE,
  parameter logic [31:0] SIZE_BYTES = SRAM1_SIZE
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_address_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_fault_o,
  output logic        mem_read_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_out_o,
  input  logic [31:0] mem_data_in_i
);

  state_e      state_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic [1:0]  rsp_fault_q;
  logic        mem_rw_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_dout_q;

  fault_e      accept_fault_d;
  logic [31:0] load_d;
  logic [31:0] merge_d;

  assign accept_fault_d = check_req(req_size_i, req_address_i, BASE_ADDR, SIZE_BYTES);

  sram1_lane_mux u_lane_mux (
    .word_i   (mem_data_in_i),
    .lane_i   (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .load_o   (load_d),
    .merge_o  (merge_d)
  );

  // Outputs are registered alongside the state they belong to, so they default to 0
  // every cycle and are only set on the edge entering the state that drives them.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= FAULT_NONE;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_dout_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= FAULT_NONE;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_dout_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            write_q  <= req_write_i;
            size_q   <= req_size_i;
            signed_q <= req_signed_i;
            addr_q   <= req_address_i;
            wdata_q  <= req_wdata_i;
            if (accept_fault_d != FAULT_NONE) begin
              rsp_fault_q <= accept_fault_d;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else if (req_write_i && req_size_i == SIZE_WORD) begin
              mem_rw_q   <= 1'b1;
              mem_addr_q <= {req_address_i[31:2], 2'b00};
              mem_dout_q <= req_wdata_i;
              state_q    <= ST_WRITE;
            end else begin
              mem_addr_q <= {req_address_i[31:2], 2'b00};
              state_q    <= ST_READ;
            end
          end
        end
        ST_READ: state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (write_q) begin
            mem_rw_q   <= 1'b1;
            mem_addr_q <= {addr_q[31:2], 2'b00};
            mem_dout_q <= merge_d;
            state_q    <= ST_WRITE;
          end else begin
            rsp_rdata_q <= load_d;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o      = (state_q == ST_IDLE) && !reset_i;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign rsp_fault_o      = rsp_fault_q;
  assign mem_read_write_o = mem_rw_q;
  assign mem_address_o    = mem_addr_q;
  assign mem_data_out_o   = mem_dout_q;

endmodule

// File: tb/tb_sram1_lsu.sv
// tb/tb_sram1_lsu.sv - directed table, reset corner and randomized checks of sram1_lsu
module tb_sram1_lsu;

  localparam longint BASE = 64'h2000_0000;
  localparam longint SIZE = 64'h0001_8000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_address, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_fault;
  logic        mem_rw;
  logic [31:0] mem_addr, mem_dout, mem_din;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram1_lsu dut (
    .clock_i         (clk),
    .reset_i         (reset),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_write_i     (req_write),
    .req_size_i      (req_size),
    .req_signed_i    (req_signed),
    .req_address_i   (req_address),
    .req_wdata_i     (req_wdata),
    .rsp_valid_o     (rsp_valid),
    .rsp_rdata_o     (rsp_rdata),
    .rsp_fault_o     (rsp_fault),
    .mem_read_write_o(mem_rw),
    .mem_address_o   (mem_addr),
    .mem_data_out_o  (mem_dout),
    .mem_data_in_i   (mem_din)
  );

  // sram1 stand-in: writes at the edge while read_write is high, read data one cycle later
  logic [31:0] sram [0:24575] = '{default: 32'h0};
  logic [31:0] sram_off;
  logic        sram_hit;
  assign sram_off = mem_addr - 32'h2000_0000;
  assign sram_hit = (mem_addr >= 32'h2000_0000) && (sram_off < 32'h0001_8000);

  always @(posedge clk) begin
    if (mem_rw && sram_hit) sram[sram_off[16:2]] <= mem_dout;
    mem_din <= sram_hit ? sram[sram_off[16:2]] : 32'h0;
  end

  // Reference model: a byte-addressed memory plus the access rules in plain arithmetic
  logic [7:0] refmem [longint];

  function automatic logic [7:0] ref_byte(input longint a);
    return refmem.exists(a) ? refmem[a] : 8'h00;
  endfunction

  function automatic logic [1:0] model_fault(input logic [1:0] sz, input logic [31:0] a);
    longint la = longint'(a);
    longint n;
    if (sz == 2'd3) return 2'd3;
    n = longint'(1) << sz;
    if (la < BASE || la + n - 1 > BASE + SIZE - 1) return 2'd1;
    if (la % n != 0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int n = 1 << sz;
    for (int i = 0; i < n; i++) v = v | (32'(ref_byte(longint'(a) + i)) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) refmem[longint'(a) + i] = wd[8*i +: 8];
  endtask

  function automatic int model_lat(input logic w, input logic [1:0] sz, input logic [1:0] f);
    if (f != 2'd0) return 1;
    if (!w) return 3;
    return (sz == 2'd2) ? 2 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic [1:0] flt, output logic wrote, output logic [31:0] waddr);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_address = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd = 32'hDEAD_0000; flt = 2'd0; wrote = 1'b0; waddr = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_rw) begin wrote = 1'b1; waddr = mem_addr; end
      if (rsp_valid) begin lat = c; rd = rsp_rdata; flt = rsp_fault; break; end
    end
    @(negedge clk);
    check("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  f;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input logic [1:0] f, input int lat);
    vec_t v;
    v.name = nm; v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
    v.rd = rd; v.f = f; v.lat = lat;
    tbl.push_back(v);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd, waddr;
    logic [1:0]  flt, mf;
    logic        wrote, seen;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_address = 32'h0; req_wdata = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_ready", {31'h0, req_ready}, 32'h0);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_mem_rw", {31'h0, mem_rw}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    reset = 1'b0;
    #1 check("ready_after_reset", {31'h0, req_ready}, 32'h1);

    add("st_w0",      1, 2, 0, 32'h2000_0000, 32'h0123_4567, 32'h0,          0, 2);
    add("ld_w0",      0, 2, 0, 32'h2000_0000, 32'h0,          32'h0123_4567, 0, 3);
    add("st_b2",      1, 0, 0, 32'h2000_0002, 32'h0000_00AA, 32'h0,          0, 4);
    add("ld_w0_b",    0, 2, 0, 32'h2000_0000, 32'h0,          32'h01AA_4567, 0, 3);
    add("ld_sb2",     0, 0, 1, 32'h2000_0002, 32'h0,          32'hFFFF_FFAA, 0, 3);
    add("ld_ub2",     0, 0, 0, 32'h2000_0002, 32'h0,          32'h0000_00AA, 0, 3);
    add("st_h0",      1, 1, 0, 32'h2000_0000, 32'h0000_8001, 32'h0,          0, 4);
    add("ld_w0_h",    0, 2, 0, 32'h2000_0000, 32'h0,          32'h01AA_8001, 0, 3);
    add("ld_sh0",     0, 1, 1, 32'h2000_0000, 32'h0,          32'hFFFF_8001, 0, 3);
    add("ld_sh2",     0, 1, 1, 32'h2000_0002, 32'h0,          32'h0000_01AA, 0, 3);
    add("st_w_end",   1, 2, 0, 32'h2001_8000, 32'h1111_2222, 32'h0,          1, 1);
    add("st_w_last",  1, 2, 0, 32'h2001_7FFC, 32'hDEAD_BEEF, 32'h0,          0, 2);
    add("ld_w_cross", 0, 2, 0, 32'h2001_7FFD, 32'h0,          32'h0,          1, 1);
    add("ld_b_last",  0, 0, 0, 32'h2001_7FFF, 32'h0,          32'h0000_00DE, 0, 3);
    add("st_w_below", 1, 2, 0, 32'h1FFF_FFFC, 32'h3333_4444, 32'h0,          1, 1);
    add("ld_h_misal", 0, 1, 0, 32'h2000_0001, 32'h0,          32'h0,          2, 1);
    add("ld_size3",   0, 3, 0, 32'h2000_0000, 32'h0,          32'h0,          3, 1);

    foreach (tbl[i]) begin
      run_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, lat, rd, flt, wrote, waddr);
      check({tbl[i].name, "_lat"}, 32'(lat), 32'(tbl[i].lat));
      check({tbl[i].name, "_fault"}, {30'h0, flt}, {30'h0, tbl[i].f});
      check({tbl[i].name, "_rdata"}, rd, tbl[i].rd);
      check({tbl[i].name, "_wrote"}, {31'h0, wrote}, {31'h0, tbl[i].w && tbl[i].f == 2'd0});
      if (tbl[i].w && tbl[i].f == 2'd0) begin
        check({tbl[i].name, "_waddr"}, waddr, {tbl[i].a[31:2], 2'b00});
        model_store(tbl[i].sz, tbl[i].a, tbl[i].wd);
      end
    end

    // Reset during the WRITE cycle of a read-modify-write byte store
    run_req(1, 2, 0, 32'h2000_0008, 32'h1122_3344, lat, rd, flt, wrote, waddr);
    check("rst_setup_lat", 32'(lat), 32'd2);
    model_store(2, 32'h2000_0008, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_address = 32'h2000_0009; req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_rw) begin seen = 1'b1; break; end
    end
    check("rst_write_reached", {31'h0, seen}, 32'h1);
    #1 reset = 1'b1;
    #1 check("rst_mem_rw_drop", {31'h0, mem_rw}, 32'h0);
    check("rst_ready_low", {31'h0, req_ready}, 32'h0);
    seen = 1'b0;
    @(negedge clk);
    if (rsp_valid) seen = 1'b1;
    reset = 1'b0;
    #1 check("rst_ready_back", {31'h0, req_ready}, 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_no_rsp", {31'h0, seen}, 32'h0);
    run_req(0, 2, 0, 32'h2000_0008, 32'h0, lat, rd, flt, wrote, waddr);
    check("rst_word_unchanged", rd, 32'h1122_3344);

    // Randomized requests against the byte-level model
    for (int it = 0; it < 120; it++) begin
      logic        w, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd, exp_rd;
      int          r;
      r = $urandom_range(0, 9);
      if (r < 6)       a = 32'h2000_0000 + $urandom_range(0, 31);
      else if (r == 6) a = 32'h2001_7FF8 + $urandom_range(0, 15);
      else if (r == 7) a = 32'h1FFF_FFFC + $urandom_range(0, 3);
      else if (r == 8) a = 32'hFFFF_FFFC + $urandom_range(0, 3);
      else             a = $urandom;
      r  = $urandom_range(0, 9);
      sz = (r == 9) ? 2'd3 : 2'(r % 3);
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom;
      mf = model_fault(sz, a);
      exp_rd = (mf == 2'd0 && !w) ? model_load(sz, sg, a) : 32'h0;
      run_req(w, sz, sg, a, wd, lat, rd, flt, wrote, waddr);
      check("rnd_lat", 32'(lat), 32'(model_lat(w, sz, mf)));
      check("rnd_fault", {30'h0, flt}, {30'h0, mf});
      check("rnd_rdata", rd, exp_rd);
      check("rnd_wrote", {31'h0, wrote}, {31'h0, w && mf == 2'd0});
      if (w && mf == 2'd0) model_store(sz, a, wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
